zoom_engine: RTL and testbench
==============================

Name: zoom_engine

Overview:
Parametrised 2x image scaling engine for the coprocessor datapath. It makes one pass over a source frame buffer and writes a full destination frame of equal size. Supported passes are copy, 2x zoom-in by pixel replication, and 2x zoom-out by decimation or by 2x2 block mean. It tracks the current zoom level and raises limit flags. The top-level FSM owns buffer selection (ping-pong) and the instruction decode.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 320, frame width in pixels (multiple of 4)
IMG_H, 240, frame height in pixels (multiple of 4)
ADDR_W, 17, buffer address width (2^ADDR_W >= IMG_W*IMG_H)
LEVELS, 2, max zoom steps either side of unity (1..7)
FILL, 0, pixel value written outside the zoom-out window

Ports:
clock  in  1  single clock; all logic on its rising edge
reset  in  1  asynchronous, active-low (0 = reset)
start  in  1  request pulse; sampled only in IDLE
mode  in  3  0 COPY, 1 ZIN_REP, 2 ZOUT_DEC, 3 ZOUT_AVG, 4 RESTORE, 5-7 invalid
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
error  out  1  request rejected; held until the next accepted start
zoom_level  out  4  signed two's-complement current level, range -LEVELS..+LEVELS
zoom_max  out  1  zoom_level == +LEVELS
zoom_min  out  1  zoom_level == -LEVELS
rd_addr  out  ADDR_W  source read address (registered)
rd_data  in  DATA_W  source data; synchronous RAM, one cycle read latency
wr_addr  out  ADDR_W  destination write address
wr_data  out  DATA_W  destination write data
wr_en  out  1  destination write strobe

Behaviour:
- Reset: outputs busy, done, error, wr_en, rd_addr, wr_addr, wr_data and zoom_level reset to 0. zoom_max and zoom_min are 0. FSM goes to IDLE. Reset mid-pass aborts the pass immediately with no further writes.
- States: IDLE, CHECK, RD, WT, WR, FIN.
- IDLE → CHECK on start. mode is latched and error cleared.
- CHECK rejects the request in any of these cases:
  - mode is invalid;
  - ZIN_REP with level == +LEVELS;
  - ZOUT_* with level == -LEVELS.
  On rejection: done=1 and error=1 for one cycle, then IDLE. There is no wr_en, and zoom_level is unchanged.
- Otherwise CHECK clears x and y to 0 and sets busy=1.
- Per destination pixel (x,y): wr_addr = y*IMG_W + x.
- Constants: X0=IMG_W/4, Y0=IMG_H/4, W2=IMG_W/2, H2=IMG_H/2.
- Source mapping:
  - COPY and RESTORE: src(x,y).
  - ZIN_REP: src(X0 + x/2, Y0 + y/2), integer divide.
  - ZOUT_DEC: inside the window (X0<=x<X0+W2 and Y0<=y<Y0+H2), src(2(x-X0), 2(y-Y0)); outside the window, FILL.
  - ZOUT_AVG: same window; the value is the mean of src(2u,2v), (2u+1,2v), (2u,2v+1), (2u+1,2v+1), with u=x-X0 and v=y-Y0.
- Read cycle: RD drives rd_addr. WT captures rd_data at the end of the cycle.
- Per-pixel timing:
  - single-read modes: RD, WT, WR = 3 cycles per pixel;
  - ZOUT_AVG: 4x(RD, WT) then WR = 9 cycles per pixel;
  - FILL pixel: WR only, 1 cycle.
- WR: wr_en=1 for exactly one cycle, with wr_addr and wr_data valid in the same cycle.
- Scan order: x advances from 0 to IMG_W-1, then wraps to 0 and y increments. The pass ends after writing (IMG_W-1, IMG_H-1).
- Mean arithmetic: the sum is DATA_W+2 bits wide and the result is sum >> 2 (truncating). No overflow is possible.
- FIN: done=1 for one cycle, busy=0, then IDLE. zoom_level updates in FIN:
  - +1 for ZIN_REP;
  - -1 for ZOUT_*;
  - 0 for RESTORE;
  - unchanged for COPY.
  zoom_max and zoom_min follow zoom_level combinationally from its register.
- start while busy is ignored; it is not queued and does not set error.
- wr_en is 0 in every state except WR.

Test Plan:
- Params IMG_W=8, IMG_H=4; source pixel p = y*8+x; COPY → 32 writes with wr_data == wr_addr, busy high for exactly 96 cycles, one done pulse, zoom_level 0.
- ZIN_REP from level 0 → dest(0,0)=10, (1,0)=10, (2,0)=11, (0,1)=10, (0,2)=18; zoom_level=1 after done.
- ZOUT_AVG → dest(0,0)=0 (FILL), dest(2,1)=(0+1+8+9)>>2=4, dest(5,2)=(22+23+30+31)>>2=26; 96 busy cycles; zoom_level=-1.
- ZOUT_DEC → dest(3,2)=src(2,2)=18, dest(7,3)=FILL; 48 busy cycles.
- LEVELS=2: ZIN_REP three times → third gives done with error=1, no wr_en, zoom_max=1, zoom_level=2; then RESTORE → zoom_level=0, zoom_max=0, error cleared; mode=6 → error=1.
- Assert reset mid-pass at pixel 10 → wr_en and busy drop to 0 asynchronously; after release, a start begins a fresh pass from pixel 0; start pulsed while busy → no effect.

Source files
------------

// File: rtl/zoom_engine.sv
// 2x image scaling engine: one pass over a source frame producing a full destination frame.
// Supports copy, zoom-in by replication, zoom-out by decimation or 2x2 mean; tracks zoom level.
module zoom_engine #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       IMG_W  = 320,
  parameter int unsigned       IMG_H  = 240,
  parameter int unsigned       ADDR_W = 17,
  parameter int unsigned       LEVELS = 2,
  parameter logic [DATA_W-1:0] FILL   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [3:0]        zoom_level,
  output logic              zoom_max,
  output logic              zoom_min,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en
);

  localparam int unsigned X0 = IMG_W / 4;
  localparam int unsigned Y0 = IMG_H / 4;
  localparam int unsigned W2 = IMG_W / 2;
  localparam int unsigned H2 = IMG_H / 2;
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);
  localparam logic [3:0] LvlMax = 4'(LEVELS);
  localparam logic [3:0] LvlMin = 4'(0 - LEVELS);

  localparam logic [2:0] ModeCopy    = 3'd0;
  localparam logic [2:0] ModeZin     = 3'd1;
  localparam logic [2:0] ModeDec     = 3'd2;
  localparam logic [2:0] ModeAvg     = 3'd3;
  localparam logic [2:0] ModeRestore = 3'd4;

  typedef enum logic [2:0] {StIdle, StCheck, StRd, StWt, StWr, StFin} state_e;

  state_e              state_q, state_d;
  logic [2:0]          mode_q, mode_d;
  logic [XW-1:0]       x_q, x_d, nx;
  logic [YW-1:0]       y_q, y_d, ny;
  logic [1:0]          sub_q, sub_d;
  logic [DATA_W+1:0]   acc_q, acc_d, sum;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [3:0]          level_q, level_d;
  logic                is_zout, reject, begin_px;

  function automatic logic [ADDR_W-1:0] pix_addr(input int unsigned sx, input int unsigned sy);
    return ADDR_W'(sy * IMG_W + sx);
  endfunction

  function automatic logic in_window(input int unsigned px, input int unsigned py);
    return (px >= X0) && (px < X0 + W2) && (py >= Y0) && (py < Y0 + H2);
  endfunction

  // sub selects the 2x2 quadrant for the mean: bit 0 steps x, bit 1 steps y.
  function automatic logic [ADDR_W-1:0] src_addr(input logic [2:0] m, input int unsigned px,
                                                 input int unsigned py, input logic [1:0] sub);
    int unsigned sx, sy;
    sx = px;
    sy = py;
    case (m)
      ModeZin: begin
        sx = X0 + px / 2;
        sy = Y0 + py / 2;
      end
      ModeDec: begin
        sx = 2 * (px - X0);
        sy = 2 * (py - Y0);
      end
      ModeAvg: begin
        sx = 2 * (px - X0) + 32'(sub[0]);
        sy = 2 * (py - Y0) + 32'(sub[1]);
      end
      default: ;
    endcase
    return pix_addr(sx, sy);
  endfunction

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    x_d       = x_q;
    y_d       = y_q;
    sub_d     = sub_q;
    acc_d     = acc_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    level_d   = level_q;
    begin_px  = 1'b0;
    nx        = '0;
    ny        = '0;
    if (state_q != StCheck) begin
      if (x_q == XLast) begin
        ny = y_q + 1'b1;
      end else begin
        nx = x_q + 1'b1;
        ny = y_q;
      end
    end
    sum     = acc_q + (DATA_W + 2)'(rd_data);
    is_zout = (mode_q == ModeDec) || (mode_q == ModeAvg);
    reject  = (mode_q > ModeRestore) || ((mode_q == ModeZin) && (level_q == LvlMax)) ||
              (is_zout && (level_q == LvlMin));

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          error_d = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (reject) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          busy_d   = 1'b1;
          begin_px = 1'b1;
        end
      end
      StRd: state_d = StWt;
      StWt: begin
        if ((mode_q == ModeAvg) && (sub_q != 2'd3)) begin
          acc_d     = sum;
          sub_d     = sub_q + 2'd1;
          rd_addr_d = src_addr(mode_q, 32'(x_q), 32'(y_q), sub_q + 2'd1);
          state_d   = StRd;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_addr(32'(x_q), 32'(y_q));
          wr_data_d = (mode_q == ModeAvg) ? DATA_W'(sum >> 2) : rd_data;
          state_d   = StWr;
        end
      end
      StWr: begin
        if ((x_q == XLast) && (y_q == YLast)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StFin;
        end else begin
          begin_px = 1'b1;
        end
      end
      StFin: begin
        if (mode_q == ModeZin)          level_d = level_q + 4'd1;
        else if (is_zout)               level_d = level_q - 4'd1;
        else if (mode_q == ModeRestore) level_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Fill pixels skip the read and go straight to the write cycle.
    if (begin_px) begin
      x_d   = nx;
      y_d   = ny;
      sub_d = '0;
      acc_d = '0;
      if (is_zout && !in_window(32'(nx), 32'(ny))) begin
        wr_en_d   = 1'b1;
        wr_addr_d = pix_addr(32'(nx), 32'(ny));
        wr_data_d = FILL;
        state_d   = StWr;
      end else begin
        rd_addr_d = src_addr(mode_q, 32'(nx), 32'(ny), 2'd0);
        state_d   = StRd;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      mode_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      sub_q     <= '0;
      acc_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sub_q     <= sub_d;
      acc_q     <= acc_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      level_q   <= level_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign zoom_level = level_q;
  assign zoom_max   = (level_q == LvlMax);
  assign zoom_min   = (level_q == LvlMin);
  assign rd_addr    = rd_addr_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;

endmodule

// File: tb/tb_zoom_engine.sv
// Bench for zoom_engine on an 8x4 frame whose source pixel value equals its address.
// A frame model checks every write; literal expectations pin the model.
module tb_zoom_engine;

  localparam int W = 8;
  localparam int H = 4;
  localparam int X0 = W / 4;
  localparam int Y0 = H / 4;
  localparam int W2 = W / 2;
  localparam int H2 = H / 2;
  localparam int FILLV = 0;

  localparam logic [2:0] MCOPY = 3'd0;
  localparam logic [2:0] MZIN  = 3'd1;
  localparam logic [2:0] MDEC  = 3'd2;
  localparam logic [2:0] MAVG  = 3'd3;
  localparam logic [2:0] MRST  = 3'd4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       busy, done, error, zoom_max, zoom_min, wr_en;
  logic [3:0] zoom_level;
  logic [4:0] rd_addr, wr_addr;
  logic [7:0] rd_data, wr_data;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int pass_base = 0;
  logic [2:0] cur_mode = 3'd0;
  logic [7:0] dest [32];

  zoom_engine #(
    .DATA_W(8), .IMG_W(W), .IMG_H(H), .ADDR_W(5), .LEVELS(2), .FILL(8'd0)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .busy(busy), .done(done),
    .error(error), .zoom_level(zoom_level), .zoom_max(zoom_max), .zoom_min(zoom_min),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
  );

  always #5 clock = ~clock;

  // Synchronous source RAM, one-cycle latency, content = address.
  always @(posedge clock) rd_data <= 8'(rd_addr);

  function automatic int src(input int x, input int y);
    return y * W + x;
  endfunction

  function automatic int exp_pix(input logic [2:0] m, input int x, input int y);
    int u, v, r;
    u = x - X0;
    v = y - Y0;
    if (m == MZIN) r = src(X0 + x / 2, Y0 + y / 2);
    else if (m == MDEC || m == MAVG) begin
      if (x < X0 || x >= X0 + W2 || y < Y0 || y >= Y0 + H2) r = FILLV;
      else if (m == MDEC) r = src(2 * u, 2 * v);
      else r = (src(2*u, 2*v) + src(2*u+1, 2*v) + src(2*u, 2*v+1) + src(2*u+1, 2*v+1)) / 4;
    end else r = src(x, y);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Every write must land in scan order with the model's pixel value.
  always @(negedge clock) begin
    if (reset && wr_en) begin
      int idx;
      idx = wr_cnt - pass_base;
      check("wr_addr", int'(wr_addr), idx);
      check("wr_data", int'(wr_data), exp_pix(cur_mode, idx % W, idx / W));
      dest[wr_addr] = wr_data;
      wr_cnt++;
    end
  end

  task automatic run_pass(input logic [2:0] m, input int exp_err, input int exp_busy,
                          input int exp_wr, input int exp_lvl, input bit poke);
    int busy_cnt;
    bit seen;
    cur_mode = m;
    pass_base = wr_cnt;
    @(negedge clock);
    start = 1'b1;
    mode = m;
    @(negedge clock);
    start = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else begin
        if (poke && busy_cnt == 20) begin
          start = 1'b1;
          mode = MZIN;
        end else start = 1'b0;
        @(negedge clock);
      end
    end
    start = 1'b0;
    check("done_seen", int'(seen), 1);
    check("error_at_done", int'(error), exp_err);
    check("busy_cycles", busy_cnt, exp_busy);
    check("write_count", wr_cnt - pass_base, exp_wr);
    @(negedge clock);
    check("done_one_cycle", int'(done), 0);
    check("error_held", int'(error), exp_err);
    check("zoom_level", int'($signed(zoom_level)), exp_lvl);
    check("zoom_max", int'(zoom_max), int'(exp_lvl == 2));
    check("zoom_min", int'(zoom_min), int'(exp_lvl == -2));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    repeat (3) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_level", int'(zoom_level), 0);
    check("rst_max", int'(zoom_max), 0);
    check("rst_min", int'(zoom_min), 0);
    reset = 1'b1;

    run_pass(MCOPY, 0, 96, 32, 0, 1'b0);

    run_pass(MAVG, 0, 96, 32, -1, 1'b0);
    check("avg_0_0", int'(dest[0]), 0);
    check("avg_2_1", int'(dest[10]), 4);
    check("avg_5_2", int'(dest[21]), 26);

    run_pass(MDEC, 0, 48, 32, -2, 1'b0);
    check("dec_3_2", int'(dest[19]), 18);
    check("dec_7_3", int'(dest[31]), 0);

    run_pass(MDEC, 1, 0, 0, -2, 1'b0);
    run_pass(MRST, 0, 96, 32, 0, 1'b0);

    run_pass(MZIN, 0, 96, 32, 1, 1'b0);
    check("zin_0_0", int'(dest[0]), 10);
    check("zin_1_0", int'(dest[1]), 10);
    check("zin_2_0", int'(dest[2]), 11);
    check("zin_0_1", int'(dest[8]), 10);
    check("zin_0_2", int'(dest[16]), 18);
    run_pass(MZIN, 0, 96, 32, 2, 1'b0);
    run_pass(MZIN, 1, 0, 0, 2, 1'b0);
    run_pass(MRST, 0, 96, 32, 0, 1'b0);
    run_pass(3'd6, 1, 0, 0, 0, 1'b0);

    // Abort a copy at pixel 10 with an asynchronous reset.
    cur_mode = MCOPY;
    pass_base = wr_cnt;
    @(negedge clock);
    start = 1'b1;
    mode = MCOPY;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (wr_en && wr_addr == 5'd10) found = 1'b1;
      else @(negedge clock);
    end
    check("reach_px10", int'(found), 1);
    reset = 1'b0;
    #1;
    check("abort_wr_en", int'(wr_en), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_wr_addr", int'(wr_addr), 0);
    @(negedge clock);
    reset = 1'b1;

    run_pass(MCOPY, 0, 96, 32, 0, 1'b1);
    pass_base = wr_cnt;
    repeat (5) @(negedge clock);
    check("no_queued_busy", int'(busy), 0);
    check("no_queued_writes", wr_cnt - pass_base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
